// File: rtl/logic_axi4_stream_merge_pkg.sv
// logic_axi4_stream_merge_pkg: shared state type and index-width helper for the stream merge
package logic_axi4_stream_merge_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/logic_arbiter_round_robin.sv
// logic_arbiter_round_robin: combinational first-set search starting at a rotating pointer
module logic_arbiter_round_robin
  import logic_axi4_stream_merge_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] i_request,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_index,
  output logic         o_valid
);
  logic [W-1:0] w_idx;
  // scan from farthest to nearest so the nearest request to ptr wins
  always_comb begin
    o_index = '0;
    o_valid = 1'b0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = W'((int'(i_ptr) + k) % N);
      if (i_request[w_idx]) begin
        o_index = w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/logic_axi4_stream_merge.sv
// logic_axi4_stream_merge: packet-aware round-robin merge of several AXI4-Stream sources into one registered sink
module logic_axi4_stream_merge
  import logic_axi4_stream_merge_pkg::*;
#(
  parameter int INPUTS      = 4,
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TLAST   = 1,
  parameter bit USE_TKEEP   = 1,
  parameter bit USE_TSTRB   = 1
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [INPUTS-1:0]                          rx_tvalid,
  input  logic [INPUTS-1:0]                          rx_tlast,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0][7:0]    rx_tdata,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0]         rx_tstrb,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0]         rx_tkeep,
  input  logic [INPUTS-1:0][TDEST_WIDTH-1:0]         rx_tdest,
  input  logic [INPUTS-1:0][TUSER_WIDTH-1:0]         rx_tuser,
  input  logic [INPUTS-1:0][TID_WIDTH-1:0]           rx_tid,
  output logic [INPUTS-1:0]                          rx_tready,
  output logic                                       tx_tvalid,
  output logic                                       tx_tlast,
  output logic [TDATA_BYTES-1:0][7:0]                tx_tdata,
  output logic [TDATA_BYTES-1:0]                     tx_tstrb,
  output logic [TDATA_BYTES-1:0]                     tx_tkeep,
  output logic [TDEST_WIDTH-1:0]                     tx_tdest,
  output logic [TUSER_WIDTH-1:0]                     tx_tuser,
  output logic [TID_WIDTH-1:0]                       tx_tid,
  input  logic                                       tx_tready
);
  localparam int W = idx_width(INPUTS);
  state_t                      r_state;
  logic [W-1:0]                r_grant, r_ptr;
  logic                        r_tvalid, r_tlast;
  logic [TDATA_BYTES-1:0][7:0] r_tdata;
  logic [TDATA_BYTES-1:0]      r_tstrb, r_tkeep;
  logic [TDEST_WIDTH-1:0]      r_tdest;
  logic [TUSER_WIDTH-1:0]      r_tuser;
  logic [TID_WIDTH-1:0]        r_tid;
  logic [W-1:0]                w_sel, w_arb_idx, w_next_ptr;
  logic                        w_arb_valid, w_free, w_xfer, w_last;
  logic_arbiter_round_robin #(.N(INPUTS), .W(W)) u_arb (
    .i_request(rx_tvalid),
    .i_ptr    (r_ptr),
    .o_index  (w_arb_idx),
    .o_valid  (w_arb_valid)
  );
  assign w_free     = !r_tvalid || tx_tready;
  assign w_sel      = (r_state == LOCKED) ? r_grant : w_arb_idx;
  assign w_xfer     = rx_tvalid[w_sel] && rx_tready[w_sel];
  assign w_last     = !USE_TLAST || rx_tlast[w_sel];
  assign w_next_ptr = (int'(w_sel) == INPUTS - 1) ? '0 : w_sel + W'(1);
  // in IDLE with nothing requesting, no source is offered ready
  always_comb begin
    rx_tready = '0;
    for (int g = 0; g < INPUTS; g++)
      rx_tready[g] = w_free && !areset && (r_state == LOCKED || w_arb_valid) && (w_sel == W'(g));
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tkeep  <= '0;
      r_tdest  <= '0;
      r_tuser  <= '0;
      r_tid    <= '0;
    end else begin
      if (w_free) r_tvalid <= w_xfer;
      if (w_xfer) begin
        r_tlast <= w_last;
        r_tdata <= rx_tdata[w_sel];
        r_tstrb <= rx_tstrb[w_sel];
        r_tkeep <= rx_tkeep[w_sel];
        r_tdest <= rx_tdest[w_sel];
        r_tuser <= rx_tuser[w_sel];
        r_tid   <= rx_tid[w_sel];
        r_state <= w_last ? IDLE : LOCKED;
        r_grant <= w_sel;
        if (w_last) r_ptr <= w_next_ptr;
      end
    end
  end
  assign tx_tvalid = r_tvalid;
  assign tx_tlast  = USE_TLAST ? r_tlast : 1'b1;
  assign tx_tdata  = r_tdata;
  assign tx_tstrb  = USE_TSTRB ? r_tstrb : '1;
  assign tx_tkeep  = USE_TKEEP ? r_tkeep : '1;
  assign tx_tdest  = r_tdest;
  assign tx_tuser  = r_tuser;
  assign tx_tid    = r_tid;
endmodule

// File: tb/tb_logic_axi4_stream_merge.sv
// tb_logic_axi4_stream_merge: table vectors plus per-source queues and an ordered scoreboard for the stream merge
module tb_logic_axi4_stream_merge;
  import logic_axi4_stream_merge_pkg::*;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        dest;
    logic        user;
    logic        id;
  } beat_t;
  typedef struct {
    logic [3:0]  vld;
    logic [31:0] d0;
    logic        l0;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_l;
    logic [3:0]  exp_r;
  } vec_t;
  logic                  clk, areset;
  logic [3:0]            rx_tvalid, rx_tlast, rx_tready;
  logic [3:0][3:0][7:0]  rx_tdata;
  logic [3:0][3:0]       rx_tstrb, rx_tkeep;
  logic [3:0][0:0]       rx_tdest, rx_tuser, rx_tid;
  logic                  tx_tvalid, tx_tlast, tx_tready;
  logic [3:0][7:0]       tx_tdata;
  logic [3:0]            tx_tstrb, tx_tkeep;
  logic [0:0]            tx_tdest, tx_tuser, tx_tid;
  logic [3:0]            n_tvalid, n_tlast, n_rready;
  logic [3:0][3:0][7:0]  n_tdata;
  logic [3:0][3:0]       n_tstrb, n_tkeep;
  logic [3:0][0:0]       n_tdest, n_tuser, n_tid;
  logic                  n_tx_tvalid, n_tx_tlast, n_tx_tready;
  logic [3:0][7:0]       n_tx_tdata;
  logic [3:0]            n_tx_tstrb, n_tx_tkeep;
  logic [0:0]            n_tx_tdest, n_tx_tuser, n_tx_tid;
  int                    n_checks = 0, n_fail = 0;
  beat_t                 src_q[4][$];
  beat_t                 exp_q[$];
  logic [3:0]            en;
  beat_t                 prev;
  logic                  armed;
  logic [3:0]            s_rdy;
  logic                  s_tvalid;
  vec_t                  tbl[10];
  logic_axi4_stream_merge dut (
    .aclk(clk), .areset(areset),
    .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep),
    .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid), .rx_tready(rx_tready),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb), .tx_tkeep(tx_tkeep),
    .tx_tdest(tx_tdest), .tx_tuser(tx_tuser), .tx_tid(tx_tid), .tx_tready(tx_tready)
  );
  logic_axi4_stream_merge #(.USE_TLAST(0)) u_nl (
    .aclk(clk), .areset(areset),
    .rx_tvalid(n_tvalid), .rx_tlast(n_tlast), .rx_tdata(n_tdata), .rx_tstrb(n_tstrb), .rx_tkeep(n_tkeep),
    .rx_tdest(n_tdest), .rx_tuser(n_tuser), .rx_tid(n_tid), .rx_tready(n_rready),
    .tx_tvalid(n_tx_tvalid), .tx_tlast(n_tx_tlast), .tx_tdata(n_tx_tdata), .tx_tstrb(n_tx_tstrb), .tx_tkeep(n_tx_tkeep),
    .tx_tdest(n_tx_tdest), .tx_tuser(n_tx_tuser), .tx_tid(n_tx_tid), .tx_tready(n_tx_tready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic beat_t mk(input int s, input int k, input bit l);
    beat_t b;
    b.data = {8'(s), 8'(k), 16'hBEEF};
    b.last = l;
    b.keep = 4'(4'hF >> k);
    b.strb = 4'(s * 3 + k);
    b.dest = 1'(k);
    b.user = 1'(s);
    b.id   = 1'(s >> 1);
    return b;
  endfunction
  function automatic beat_t tx_beat();
    beat_t b;
    b.data = tx_tdata;
    b.last = tx_tlast;
    b.keep = tx_tkeep;
    b.strb = tx_tstrb;
    b.dest = tx_tdest[0];
    b.user = tx_tuser[0];
    b.id   = tx_tid[0];
    return b;
  endfunction
  task automatic present();
    beat_t b;
    for (int g = 0; g < 4; g++) begin
      rx_tvalid[g] = en[g] && (src_q[g].size() > 0);
      if (src_q[g].size() > 0) begin
        b = src_q[g][0];
        rx_tdata[g] = b.data;
        rx_tlast[g] = b.last;
        rx_tkeep[g] = b.keep;
        rx_tstrb[g] = b.strb;
        rx_tdest[g] = b.dest;
        rx_tuser[g] = b.user;
        rx_tid[g]   = b.id;
      end
    end
  endtask
  task automatic step();
    logic [3:0] fired;
    beat_t      cur;
    @(negedge clk);
    cur = tx_beat();
    s_rdy = rx_tready;
    s_tvalid = tx_tvalid;
    if (armed) chk("stall_hold", 64'(cur), 64'(prev));
    if (tx_tvalid && tx_tready) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("sb_beat", 64'(cur), 64'(exp_q.pop_front()));
    end
    armed = tx_tvalid && !tx_tready && !areset;
    prev = cur;
    fired = rx_tvalid & rx_tready;
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) if (fired[g]) void'(src_q[g].pop_front());
    present();
  endtask
  task automatic drain(input string nm, input int max);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      step();
      n++;
    end
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask
  task automatic load(input int s, input int beats);
    for (int k = 0; k < beats; k++) begin
      src_q[s].push_back(mk(s, k, k == beats - 1));
      exp_q.push_back(mk(s, k, k == beats - 1));
    end
  endtask
  initial begin
    int n, first, last, cnt, k;
    areset = 1'b1; tx_tready = 1'b0; en = '0; armed = 1'b0;
    rx_tvalid = '0; rx_tlast = '0; rx_tdata = '0; rx_tstrb = '0; rx_tkeep = '0;
    rx_tdest = '0; rx_tuser = '0; rx_tid = '0;
    n_tvalid = '0; n_tlast = '0; n_tdata = '0; n_tstrb = '0; n_tkeep = '0;
    n_tdest = '0; n_tuser = '0; n_tid = '0; n_tx_tready = 1'b1;
    tbl[0] = '{4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0000};
    tbl[1] = '{4'b0001, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0001};
    tbl[2] = '{4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 4'b0000};
    tbl[3] = '{4'b0001, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 4'b0000};
    tbl[4] = '{4'b0001, 32'h11111111, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 4'b0001};
    tbl[5] = '{4'b0001, 32'h22222222, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 4'b0000};
    tbl[6] = '{4'b0001, 32'h22222222, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 4'b0000};
    tbl[7] = '{4'b0001, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0, 4'b0001};
    tbl[8] = '{4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 4'b0000};
    tbl[9] = '{4'b0000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h22222222, 1'b1, 4'b0000};
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx_tvalid = tbl[i].vld;
      rx_tdata[0] = tbl[i].d0;
      rx_tlast[0] = tbl[i].l0;
      tx_tready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_tvalid", i), 64'(tx_tvalid), 64'(tbl[i].exp_v));
      chk($sformatf("row%0d_tdata", i), 64'(tx_tdata), 64'(tbl[i].exp_d));
      chk($sformatf("row%0d_tlast", i), 64'(tx_tlast), 64'(tbl[i].exp_l));
      chk($sformatf("row%0d_rready", i), 64'(rx_tready), 64'(tbl[i].exp_r));
      if (i == 2) chk("ptr_after_single", 64'(dut.r_ptr), 64'(1));
      @(posedge clk);
      #1;
    end
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
    tx_tready = 1'b1;
    en = 4'hF;
    for (int s = 0; s < 4; s++) load(s, 3);
    present();
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (s_tvalid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("rr_valid_cycles", 64'(cnt), 64'(12));
    chk("rr_no_bubble", 64'(last - first + 1), 64'(12));
    chk("rr_sb_empty", 64'(exp_q.size()), 64'(0));
    load(1, 3);
    load(2, 2);
    present();
    n = 0;
    while (src_q[1].size() > 2 && n < 10) begin
      step();
      n++;
    end
    chk("gap_first_beat", 64'(src_q[1].size()), 64'(2));
    en[1] = 1'b0;
    present();
    for (int c = 0; c < 2; c++) begin
      step();
      chk("gap_rready2", 64'(s_rdy[2]), 64'(0));
    end
    chk("gap_tx_drained", 64'(s_tvalid), 64'(0));
    en[1] = 1'b1;
    present();
    drain("gap", 20);
    load(0, 4);
    load(2, 2);
    present();
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      tx_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("stall_drain", 64'(exp_q.size()), 64'(0));
    tx_tready = 1'b1;
    load(3, 4);
    present();
    n = 0;
    while (src_q[3].size() > 2 && n < 10) begin
      step();
      n++;
    end
    chk("rst_two_beats_in", 64'(src_q[3].size()), 64'(2));
    areset = 1'b1;
    tx_tready = 1'b0;
    step();
    chk("rst_rready", 64'(s_rdy), 64'(0));
    areset = 1'b0;
    exp_q.delete();
    src_q[3].delete();
    tx_tready = 1'b1;
    present();
    @(negedge clk);
    chk("rst_tvalid", 64'(tx_tvalid), 64'(0));
    chk("rst_state", 64'(dut.r_state), 64'(IDLE));
    chk("rst_ptr", 64'(dut.r_ptr), 64'(0));
    @(posedge clk);
    #1;
    load(0, 1);
    load(3, 1);
    present();
    drain("rst_arb", 20);
    n_tvalid = 4'b0011;
    n_tdata[0] = 32'hAAAA0000;
    n_tdata[1] = 32'hBBBB1111;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (n_tx_tvalid) begin
        chk("nl_data", 64'(n_tx_tdata), (k % 2 == 0) ? 64'hAAAA0000 : 64'hBBBB1111);
        chk("nl_last", 64'(n_tx_tlast), 64'(1));
        k++;
      end
    end
    chk("nl_beats", 64'(k), 64'(9));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
